// File: rtl/fpnew_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// fpnew_issue_ctrl_if
//
// Groups the host-side command/response streams and the FPU-side
// valid/ready/tag streams of the issue controller into a single bundle.
//
// Signal groups:
//   host command  : req_valid_i, req_ready_o, req_operands_i, req_cmd_i, flush_i
//   FPU issue     : fpu_in_valid_o, fpu_in_ready_i, fpu_operands_o, fpu_cmd_o,
//                   fpu_tag_o, fpu_flush_o
//   FPU completion: fpu_out_valid_i, fpu_out_ready_o, fpu_result_i,
//                   fpu_status_i, fpu_tag_i
//   host response : rsp_valid_o, rsp_ready_i, rsp_result_o, rsp_status_o
//
// Signal names keep the controller's point of view (_i = into the controller).
// Modports:
//   master : the issue controller itself
//   slave  : the environment around it (host plus FPU wrapper)
// -----------------------------------------------------------------------------
interface fpnew_issue_ctrl_if #(
  parameter int FLEN      = 64,
  parameter int TAG_WIDTH = 2,
  parameter int CMD_WIDTH = 16
);

  // Host command stream
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [3*FLEN-1:0]      req_operands_i;
  logic [CMD_WIDTH-1:0]   req_cmd_i;
  logic                   flush_i;

  // FPU issue side
  logic                   fpu_in_valid_o;
  logic                   fpu_in_ready_i;
  logic [3*FLEN-1:0]      fpu_operands_o;
  logic [CMD_WIDTH-1:0]   fpu_cmd_o;
  logic [TAG_WIDTH-1:0]   fpu_tag_o;
  logic                   fpu_flush_o;

  // FPU completion side
  logic                   fpu_out_valid_i;
  logic                   fpu_out_ready_o;
  logic [FLEN-1:0]        fpu_result_i;
  logic [4:0]             fpu_status_i;
  logic [TAG_WIDTH-1:0]   fpu_tag_i;

  // Host response stream
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [FLEN-1:0]        rsp_result_o;
  logic [4:0]             rsp_status_o;

  modport master (
    input  req_valid_i, req_operands_i, req_cmd_i, flush_i,
    output req_ready_o,
    output fpu_in_valid_o, fpu_operands_o, fpu_cmd_o, fpu_tag_o, fpu_flush_o,
    input  fpu_in_ready_i,
    input  fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
    output fpu_out_ready_o,
    output rsp_valid_o, rsp_result_o, rsp_status_o,
    input  rsp_ready_i
  );

  modport slave (
    output req_valid_i, req_operands_i, req_cmd_i, flush_i,
    input  req_ready_o,
    input  fpu_in_valid_o, fpu_operands_o, fpu_cmd_o, fpu_tag_o, fpu_flush_o,
    output fpu_in_ready_i,
    output fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
    input  fpu_out_ready_o,
    input  rsp_valid_o, rsp_result_o, rsp_status_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/fpnew_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpnew_issue_ctrl
//
// Initiator-side controller for the FPU wrapper's valid/ready/tag protocol.
// Host commands pass straight through to the FPU, each stamped with the next
// sequential tag. Completions may come back in any order; they are parked in
// a reorder buffer indexed by tag and handed back to the host strictly in
// issue order. A host flush aborts all outstanding work and pulses the FPU
// flush line for one cycle.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : host and FPU streams (fpnew_issue_ctrl_if.master)
//   busy_o  : work outstanding, or a flush in progress
//   err_o   : sticky protocol error (unexpected completion tag)
// -----------------------------------------------------------------------------
module fpnew_issue_ctrl #(
  parameter int FLEN      = 64,
  parameter int TAG_WIDTH = 2,
  parameter int CMD_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  fpnew_issue_ctrl_if.master        bus,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int DEPTH = 2 ** TAG_WIDTH;

  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [TAG_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  // Flush sequencing: RUN is normal operation, FLUSH is the single cycle in
  // which the FPU flush line is driven after the host requested an abort.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  flush_state_e state_q, state_next;

  // ---------------------------------------------------------------------------
  // Reorder buffer state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] done_q;
  logic [FLEN-1:0]  result_q [DEPTH];
  logic [4:0]       status_q [DEPTH];
  tag_t             head_q;
  tag_t             tail_q;
  cnt_t             count_q;
  logic             err_q;

  // ---------------------------------------------------------------------------
  // Issue path (combinational pass-through)
  // ---------------------------------------------------------------------------
  logic not_full;
  logic issue_ok;
  logic issue;

  // The full check uses the count before any same-cycle retire, so a full
  // buffer never reissues the tag that is just leaving at the head.
  assign not_full = (count_q < DEPTH_CNT);
  assign issue_ok = not_full & ~bus.flush_i;

  assign bus.fpu_in_valid_o = bus.req_valid_i & issue_ok;
  assign bus.req_ready_o    = bus.fpu_in_ready_i & issue_ok;
  assign bus.fpu_tag_o      = tail_q;
  assign bus.fpu_operands_o = bus.req_operands_i;
  assign bus.fpu_cmd_o      = bus.req_cmd_i;

  assign issue = bus.req_valid_i & issue_ok & bus.fpu_in_ready_i;

  // ---------------------------------------------------------------------------
  // Completion path
  // ---------------------------------------------------------------------------
  // Every issued tag owns a slot, so completions are never back-pressured.
  assign bus.fpu_out_ready_o = 1'b1;

  tag_t cpl_tag;
  logic cpl_ignore;
  logic cpl_hit;
  logic cpl_accept;
  logic cpl_error;

  assign cpl_tag    = bus.fpu_tag_i;
  // Anything returning while a flush is requested or being carried out
  // belongs to aborted work and is dropped silently.
  assign cpl_ignore = bus.flush_i | (state_q == ST_FLUSH);
  assign cpl_hit    = pending_q[cpl_tag] & ~done_q[cpl_tag];
  assign cpl_accept = bus.fpu_out_valid_i & ~cpl_ignore & cpl_hit;
  // A tag that was never issued, or that already completed, is a protocol
  // violation by the FPU side.
  assign cpl_error  = bus.fpu_out_valid_i & ~cpl_ignore & ~cpl_hit;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  logic rsp_valid;
  logic retire;

  assign rsp_valid = pending_q[head_q] & done_q[head_q];
  assign retire    = rsp_valid & bus.rsp_ready_i;

  assign bus.rsp_valid_o  = rsp_valid;
  // Payload is gated by valid so stale buffer contents never reach the host.
  assign bus.rsp_result_o = rsp_valid ? result_q[head_q] : '0;
  assign bus.rsp_status_o = rsp_valid ? status_q[head_q] : '0;

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next      = ST_RUN;
    bus.fpu_flush_o = 1'b0;
    unique case (state_q)
      ST_RUN:   bus.fpu_flush_o = 1'b0;
      ST_FLUSH: bus.fpu_flush_o = 1'b1;
      default:  bus.fpu_flush_o = 1'b0;
    endcase
    // A flush request always leads to exactly one flush cycle; a request that
    // arrives during that cycle earns another one.
    if (bus.flush_i) begin
      state_next = ST_FLUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: entry flags, pointers, count, error
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else if (bus.flush_i) begin
      // Abort everything; the error flag deliberately survives a flush.
      pending_q <= '0;
      done_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      // Issue, completion and retire touch disjoint entries in any one cycle:
      // issue needs a free slot at tail, completion needs a pending-not-done
      // slot, retire needs a done slot at head.
      if (issue) begin
        pending_q[tail_q] <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        tail_q            <= tail_q + 1'b1;
      end

      if (cpl_accept) begin
        done_q[cpl_tag] <= 1'b1;
      end

      if (retire) begin
        pending_q[head_q] <= 1'b0;
        done_q[head_q]    <= 1'b0;
        head_q            <= head_q + 1'b1;
      end

      unique case ({issue, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (cpl_error) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result/status storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload arrays have no reset; an entry is only ever read while
  // its done flag is set, and that flag is reset, so the contents after reset
  // are never observable.
  always_ff @(posedge clk_i) begin
    if (cpl_accept) begin
      result_q[cpl_tag] <= bus.fpu_result_i;
      status_q[cpl_tag] <= bus.fpu_status_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign busy_o = (count_q != '0) | bus.fpu_flush_o;
  assign err_o  = err_q;

endmodule

// File: tb/tb_fpnew_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpnew_issue_ctrl
//
// Self-checking bench for fpnew_issue_ctrl. The reference model is an ordered
// queue of issued operations: the front of the queue is the next response,
// completions mark an entry by tag, flush empties the queue.
// -----------------------------------------------------------------------------
module tb_fpnew_issue_ctrl;

  localparam int FLEN  = 64;
  localparam int TW    = 2;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam logic [63:0] ONE = 64'h3FF0_0000_0000_0000;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic busy;
  logic err;

  always #5 clk_i = ~clk_i;

  fpnew_issue_ctrl_if #(.FLEN(FLEN), .TAG_WIDTH(TW), .CMD_WIDTH(CW)) bus ();

  fpnew_issue_ctrl #(.FLEN(FLEN), .TAG_WIDTH(TW), .CMD_WIDTH(CW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [TW-1:0] tag;
    bit            done;
    logic [63:0]   res;
    logic [4:0]    st;
  } ent_t;

  ent_t          mq[$];
  logic [TW-1:0] mtail;
  bit            mflush;
  bit            merr;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mtail  = '0;
    mflush = 1'b0;
    merr   = 1'b0;
  endtask

  // Apply inputs for one cycle (called just after a falling edge).
  task automatic drive(input bit rv, input bit ir, input bit ov, input logic [TW-1:0] ot,
                       input logic [63:0] res, input logic [4:0] st, input bit rr, input bit fl);
    bus.req_valid_i     = rv;
    bus.fpu_in_ready_i  = ir;
    bus.fpu_out_valid_i = ov;
    bus.fpu_tag_i       = ot;
    bus.fpu_result_i    = res;
    bus.fpu_status_i    = st;
    bus.rsp_ready_i     = rr;
    bus.flush_i         = fl;
    bus.req_operands_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.req_cmd_i       = CW'($urandom);
    #1;
  endtask

  // Compare all outputs with the model, advance the model, move to next cycle.
  task automatic tick();
    int n;
    bit room, exp_iv, exp_rdy, exp_rv, do_issue, do_retire, hit;
    ent_t e;
    n       = mq.size();
    room    = (n < DEPTH) && !bus.flush_i;
    exp_iv  = bus.req_valid_i && room;
    exp_rdy = bus.fpu_in_ready_i && room;
    exp_rv  = (n > 0) && mq[0].done;

    check("in_valid",  bus.fpu_in_valid_o,  exp_iv);
    check("req_ready", bus.req_ready_o,     exp_rdy);
    check("fpu_tag",   bus.fpu_tag_o,       mtail);
    check("operands",  bus.fpu_operands_o,  bus.req_operands_i);
    check("cmd",       bus.fpu_cmd_o,       bus.req_cmd_i);
    check("out_ready", bus.fpu_out_ready_o, 1'b1);
    check("fpu_flush", bus.fpu_flush_o,     mflush);
    check("rsp_valid", bus.rsp_valid_o,     exp_rv);
    check("busy",      busy,                (n != 0) || mflush);
    check("err",       err,                 merr);
    if (exp_rv) begin
      check("rsp_result", bus.rsp_result_o, mq[0].res);
      check("rsp_status", bus.rsp_status_o, mq[0].st);
    end

    do_issue  = exp_iv && bus.fpu_in_ready_i;
    do_retire = exp_rv && bus.rsp_ready_i;
    if (bus.flush_i) begin
      mq.delete();
      mtail  = '0;
      mflush = 1'b1;
    end else begin
      if (bus.fpu_out_valid_i && !mflush) begin
        hit = 1'b0;
        foreach (mq[i]) begin
          if (mq[i].tag == bus.fpu_tag_i && !mq[i].done) begin
            mq[i].done = 1'b1;
            mq[i].res  = bus.fpu_result_i;
            mq[i].st   = bus.fpu_status_i;
            hit        = 1'b1;
          end
        end
        if (!hit) merr = 1'b1;
      end
      if (do_retire) void'(mq.pop_front());
      if (do_issue) begin
        e.tag  = mtail;
        e.done = 1'b0;
        e.res  = '0;
        e.st   = '0;
        mq.push_back(e);
        mtail++;
      end
      mflush = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    tick();
  endtask

  // Index of a random not-yet-completed model entry, or -1.
  function automatic int pick_open();
    int c[$];
    foreach (mq[i]) if (!mq[i].done) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    logic [63:0]   rres [4];
    int            order [4];
    int            k;
    bit            ov;
    logic [TW-1:0] ot;

    // ---- reset ----
    rst_ni = 1'b0;
    model_reset();
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_in_valid",  bus.fpu_in_valid_o,  1'b0);
    check("rst_req_ready", bus.req_ready_o,     1'b0);
    check("rst_rsp_valid", bus.rsp_valid_o,     1'b0);
    check("rst_rsp_res",   bus.rsp_result_o,    64'd0);
    check("rst_flush",     bus.fpu_flush_o,     1'b0);
    check("rst_out_ready", bus.fpu_out_ready_o, 1'b1);
    check("rst_busy",      busy,                1'b0);
    check("rst_err",       err,                 1'b0);
    check("rst_tag",       bus.fpu_tag_o,       2'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // ---- single op ----
    drive(1, 1, 0, '0, '0, '0, 0, 0);
    check("single_tag", bus.fpu_tag_o, 2'd0);
    check("single_iv",  bus.fpu_in_valid_o, 1'b1);
    tick();
    idle_cycle();
    idle_cycle();
    drive(0, 0, 1, 2'd0, ONE, 5'd0, 0, 0);
    check("single_early", bus.rsp_valid_o, 1'b0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 1, 0);
    check("single_rv",   bus.rsp_valid_o,  1'b1);
    check("single_res",  bus.rsp_result_o, ONE);
    check("single_st",   bus.rsp_status_o, 5'd0);
    check("single_busy", busy, 1'b1);
    tick();
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    check("single_idle", busy, 1'b0);
    tick();

    // ---- reorder (realign tags with a flush first) ----
    drive(0, 0, 0, '0, '0, '0, 0, 1);
    tick();
    idle_cycle();
    for (int i = 0; i < 4; i++) begin
      rres[i] = {$urandom, $urandom};
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      check("ro_tag", bus.fpu_tag_o, i[TW-1:0]);
      tick();
    end
    drive(1, 1, 0, '0, '0, '0, 0, 0);
    check("ro_full_ready", bus.req_ready_o, 1'b0);
    check("ro_full_iv",    bus.fpu_in_valid_o, 1'b0);
    tick();
    order = '{2, 0, 3, 1};
    for (int j = 0; j < 4; j++) begin
      drive(0, 1, 1, order[j][TW-1:0], rres[order[j]], 5'(order[j] + 1), 0, 0);
      check("ro_cpl_ready", bus.req_ready_o, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, '0, '0, '0, 1, 0);
      check("ro_rv",  bus.rsp_valid_o,  1'b1);
      check("ro_res", bus.rsp_result_o, rres[i]);
      check("ro_st",  bus.rsp_status_o, 5'(i + 1));
      check("ro_ready_after", bus.req_ready_o, i != 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    check("ro_idle", busy, 1'b0);
    tick();

    // ---- backpressure ----
    for (int i = 0; i < 4; i++) begin
      rres[i] = {$urandom, $urandom};
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      tick();
    end
    order = '{1, 3, 0, 2};
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 1, order[j][TW-1:0], rres[order[j]], 5'd0, 0, 0);
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      check("bp_rv",    bus.rsp_valid_o,  1'b1);
      check("bp_res",   bus.rsp_result_o, rres[0]);
      check("bp_ready", bus.req_ready_o,  1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, '0, '0, '0, 1, 0);
      check("bp_rel_rv",  bus.rsp_valid_o,  1'b1);
      check("bp_rel_res", bus.rsp_result_o, rres[i]);
      tick();
    end
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    check("bp_idle", busy, 1'b0);
    tick();

    // ---- simultaneous issue/complete/retire with 3 held ----
    for (int i = 0; i < 4; i++) rres[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 2'd0, rres[0], 5'd3, 0, 0);
    tick();
    drive(1, 1, 1, 2'd1, rres[1], 5'd4, 1, 0);
    check("sim_rv",  bus.rsp_valid_o,    1'b1);
    check("sim_res", bus.rsp_result_o,   rres[0]);
    check("sim_iv",  bus.fpu_in_valid_o, 1'b1);
    check("sim_tag", bus.fpu_tag_o,      2'd3);
    tick();
    drive(0, 1, 1, 2'd2, rres[2], 5'd5, 0, 0);
    check("sim_held_ready", bus.req_ready_o, 1'b1);
    tick();
    drive(0, 0, 1, 2'd3, rres[3], 5'd6, 0, 0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, '0, '0, '0, 1, 0);
      check("sim_ret_res", bus.rsp_result_o, rres[i]);
      tick();
    end
    idle_cycle();

    // ---- flush with a completion in the same cycle ----
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      tick();
    end
    drive(1, 1, 1, 2'd0, {$urandom, $urandom}, 5'd1, 0, 1);
    check("fl_iv",    bus.fpu_in_valid_o, 1'b0);
    check("fl_ready", bus.req_ready_o,    1'b0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 1, 0);
    check("fl_pulse", bus.fpu_flush_o, 1'b1);
    check("fl_rv",    bus.rsp_valid_o, 1'b0);
    check("fl_err",   err, 1'b0);
    tick();
    drive(1, 1, 0, '0, '0, '0, 0, 0);
    check("fl_pulse_end", bus.fpu_flush_o, 1'b0);
    check("fl_new_tag",   bus.fpu_tag_o,   2'd0);
    check("fl_count0",    busy,            1'b0);
    tick();
    rres[0] = {$urandom, $urandom};
    drive(0, 0, 1, 2'd0, rres[0], 5'd2, 0, 0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 1, 0);
    check("fl_after_res", bus.rsp_result_o, rres[0]);
    tick();

    // ---- randomized traffic ----
    for (int c = 0; c < 600; c++) begin
      k  = pick_open();
      ov = (k >= 0) && ($urandom_range(0, 1) == 1);
      ot = ov ? mq[k].tag : TW'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ov, ot,
            {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0);
      tick();
    end
    for (int c = 0; c < 200 && mq.size() != 0; c++) begin
      k  = pick_open();
      ov = (k >= 0);
      ot = ov ? mq[k].tag : '0;
      drive(0, 0, ov, ot, {$urandom, $urandom}, 5'($urandom), 1, 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    check("drain_busy", busy, 1'b0);
    tick();

    // ---- protocol error: completion for an unissued tag ----
    drive(0, 0, 1, 2'd2, {$urandom, $urandom}, 5'd0, 1, 0);
    check("err_before", err, 1'b0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 1, 0);
    check("err_set", err, 1'b1);
    check("err_no_rsp", bus.rsp_valid_o, 1'b0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 0, 1);
    tick();
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    check("err_kept_flush", err, 1'b1);
    tick();

    // ---- asynchronous reset mid-operation ----
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, '0, '0, '0, 0, 0);
      tick();
    end
    drive(0, 0, 1, mq[0].tag, {$urandom, $urandom}, 5'd0, 0, 0);
    tick();
    drive(0, 0, 0, '0, '0, '0, 0, 0);
    rst_ni = 1'b0;
    #1;
    check("arst_busy",      busy,                1'b0);
    check("arst_err",       err,                 1'b0);
    check("arst_rv",        bus.rsp_valid_o,     1'b0);
    check("arst_flush",     bus.fpu_flush_o,     1'b0);
    check("arst_tag",       bus.fpu_tag_o,       2'd0);
    check("arst_out_ready", bus.fpu_out_ready_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpnew_issue_ctrl.md
Name: fpnew_issue_ctrl

Overview:
Initiator-side controller for the FPU wrapper's valid/ready/tag protocol.
- Accepts FPU commands from a host stream.
- Assigns each command a sequential tag and drives it into the FPU.
- Captures out-of-order completions into a reorder buffer indexed by tag.
- Returns results to the host strictly in issue order.
- Sits between the core's FP dispatch logic and the FPU wrapper; also owns flush sequencing.

Parameters:
FLEN, 64, operand/result width in bits
TAG_WIDTH, 2, tag width; reorder depth DEPTH = 2**TAG_WIDTH
CMD_WIDTH, 16, opaque command word (rnd_mode/op/op_mod/fmts/vectorial), forwarded unmodified

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  host command valid
req_ready_o  out  1  host command accepted when high with req_valid_i
req_operands_i  in  3*FLEN  three operands
req_cmd_i  in  CMD_WIDTH  command word
flush_i  in  1  host abort of all outstanding work
fpu_in_valid_o  out  1  to FPU in_valid_i
fpu_in_ready_i  in  1  from FPU in_ready_o
fpu_operands_o  out  3*FLEN  to FPU operands_i
fpu_cmd_o  out  CMD_WIDTH  to FPU command fields
fpu_tag_o  out  TAG_WIDTH  to FPU tag_i
fpu_flush_o  out  1  to FPU flush_i
fpu_out_valid_i  in  1  from FPU out_valid_o
fpu_out_ready_o  out  1  to FPU out_ready_i
fpu_result_i  in  FLEN  from FPU result_o
fpu_status_i  in  5  from FPU status_o (NV,DZ,OF,UF,NX)
fpu_tag_i  in  TAG_WIDTH  from FPU tag_o
rsp_valid_o  out  1  in-order result valid
rsp_ready_i  in  1  host accepts result
rsp_result_o  out  FLEN  result
rsp_status_o  out  5  status flags
busy_o  out  1  any entry pending, or flush in progress
err_o  out  1  sticky protocol error

Behaviour:
- State per entry i: pending[i], done[i], result[i], status[i].
- Pointers head, tail (TAG_WIDTH bits, natural wrap) and count (TAG_WIDTH+1 bits).
- Reset: all bits clear, pointers and count 0, err_o 0, fpu_flush_o 0. All outputs low except fpu_out_ready_o=1.
- Issue path is combinational pass-through:
  - fpu_in_valid_o = req_valid_i & (count<DEPTH) & !flush_i
  - req_ready_o = fpu_in_ready_i & (count<DEPTH) & !flush_i
  - fpu_tag_o = tail; operands and cmd are forwarded directly.
- Issue handshake (fpu_in_valid_o & fpu_in_ready_i): pending[tail]<=1, done[tail]<=0, tail<=tail+1.
- Full (count==DEPTH): no issue. fpu_in_valid_o must not assert, so in-flight tags are never reused.
- fpu_out_ready_o is constant 1; a slot always exists for every issued tag.
- Completion (fpu_out_valid_i), with t = fpu_tag_i:
  - If pending[t] & !done[t]: store result/status, done[t]<=1.
  - Otherwise: drop the data and set err_o (sticky until reset).
- Response outputs are registered from head: rsp_valid_o = pending[head] & done[head]. Minimum latency is one cycle from completion to rsp_valid_o.
- Retire (rsp_valid_o & rsp_ready_i): pending[head]<=0, done[head]<=0, head<=head+1.
- rsp_valid_o holds, with data stable, until accepted.
- Same cycle issue and retire: count unchanged, and it may stay at DEPTH while a slot frees. Issue uses the pre-retire count, so an issue is not allowed in the same cycle the full buffer retires.
- Completion landing on head in the same cycle as retire of the previous head: both take effect.
- Flush (flush_i=1, any cycle):
  - Next cycle: fpu_flush_o=1 for exactly one cycle; all pending/done cleared; head=tail=count=0.
  - Issue is blocked during the flush_i cycle.
  - Completions arriving in the flush_i cycle or the fpu_flush_o cycle are discarded without setting err_o.
  - rsp_valid_o is 0 in the cycle after flush_i.
  - err_o is retained.
- busy_o = (count!=0) | fpu_flush_o.
- Asynchronous reset mid-operation returns everything to reset values immediately, with no pending output glitches held.

Test Plan:
- Single op: issue with fpu_in_ready_i=1, FPU returns tag 0 and result 0x3FF0000000000000 three cycles later → rsp_valid_o one cycle after, result and status 0 match, busy_o falls after retire.
- Reorder: issue tags 0,1,2,3 and complete in order 2,0,3,1 → rsp order is tag 0,1,2,3 results. After the 4th issue, req_ready_o=0 until the first retire.
- Backpressure: rsp_ready_i=0 for 10 cycles with 4 completed entries → rsp_valid_o held with stable data, req_ready_o=0. Release → 4 consecutive retires, one per cycle.
- Simultaneous: buffer holding 3, with issue, completion and retire all in one cycle → count stays 3, tail and head each advance by 1, no entry lost.
- Flush: 3 outstanding, flush_i pulses, a completion arrives in the same cycle → fpu_flush_o high for one cycle, rsp_valid_o=0, count=0, err_o=0. A new issue after that gets tag 0.
- Error: completion with an unpending tag 2 → err_o=1 and stays 1 through a later flush; no rsp generated.
